d_sram_bridge: RTL and testbench
================================

# d_sram_bridge

Converts the M-stage single-cycle data SRAM port, as driven by the load/store unit, into the handshaked SRAM-like data bus. It issues one bus transaction per memory instruction and stalls the pipeline until the transaction completes. It holds the returned word until the whole pipeline advances. It sits between the M-stage load/store unit and the data-side bus arbiter/AXI adapter.

## Interface
Parameters:
- none (address/data widths fixed at 32).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  M-stage access valid; upstream deasserts it for faulting (adel/ades) accesses.
- data_sram_wen  in  4  byte-lane write enables from the store unit; 0000 means read.
- data_sram_addr  in  32  byte address (alu_resM).
- data_sram_wdata  in  32  lane-replicated store data.
- data_sram_rdata  out  32  read word to the load unit; extraction happens downstream.
- flush  in  1  exception/ERET flush of the M stage.
- longest_stall  in  1  global pipeline stall; the pipeline advances only when it is 0.
- d_stall  out  1  stall request from this block.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  bus address.
- data_wdata  out  32  bus write data.
- data_rdata  in  32  bus read data.
- data_addr_ok  in  1  request accepted when it is high together with data_req.
- data_data_ok  in  1  response valid, one cycle per transaction.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- IDLE:
  - If en=1 and flush=0, latch wr, size, addr and wdata, then go to REQ.
  - If en=1 and flush=1, stay in IDLE and issue nothing.
- REQ: data_req=1 and the latched fields are held stable.
  - addr_ok=1 and data_ok=0: go to WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle: go to HOLD, or to IDLE if flushed.
  - addr_ok=0: stay in REQ.
- WAIT: data_req=0.
  - On data_ok, latch data_rdata into rdata_r for reads, then go to HOLD, or to IDLE if flushed.
- HOLD: data_sram_rdata=rdata_r. Go to IDLE when longest_stall=0, so the pipeline advances at that same edge. The access is never re-issued while other stages stall.
- Flush tracking:
  - A sticky flushed_r flag is set if flush=1 in REQ or WAIT.
  - The bus transaction is never cancelled.
  - When the transaction completes with flushed_r set, the FSM skips HOLD, goes to IDLE, and clears flushed_r.
- d_stall = (IDLE & en & ~flush) | REQ | WAIT. It is 0 in HOLD.
- Size and address mapping:
  - wen 0000: read, size 2, addr = {addr[31:2],2'b00}.
  - wen 1111: size 2, addr aligned.
  - wen 0011: size 1, low address bits 00.
  - wen 1100: size 1, low address bits 10.
  - wen 0001/0010/0100/1000: size 0, low address bits 00/01/10/11.
  - Any other wen pattern: word write, size 2, aligned.
- data_wdata passes the latched wdata unchanged.

## Timing
- Reset values:
  - state IDLE.
  - data_req 0, data_wr 0, data_size 0, data_addr 0, data_wdata 0.
  - rdata_r 0, flushed_r 0.
  - d_stall follows its equation.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and data_req drops. The bus side shares resetn.
- Best case, read with addr_ok immediate and data_ok the following cycle:
  - c0: IDLE, en=1.
  - c1: REQ with addr_ok.
  - c2: WAIT with data_ok.
  - c3: HOLD, d_stall=0.
  - Pipeline advances at the end of c3. That is 3 stall cycles.
- data_req is registered, never combinational from en.
- Back-to-back accesses: after HOLD→IDLE, a new en is sampled in the next cycle.

## Configuration
- DSRAM_BRIDGE_RDATA_BYPASS_EN defined:
  - In the data_ok cycle (REQ or WAIT, not flushed), data_sram_rdata = data_rdata combinationally and d_stall=0.
  - If longest_stall=0 in that cycle, the FSM goes straight to IDLE. Otherwise it goes to HOLD as normal.
  - Best-case read stall drops to 2 cycles.
- Undefined: every completed, unflushed transaction passes through HOLD.

## Structure
- Add to defines.vh:
  - state encodings DSB_IDLE/REQ/WAIT/HOLD (2 bits).
  - size constants SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2.
- One sub-module, dsram_size_dec: combinational mapping from wen and addr to wr, size and bus address.

## Test plan
- Read of addr 0x1000_0006, addr_ok immediate, data_ok 1 cycle later with 0xA1B2C3D4:
  - Bus sees size 2, addr 0x1000_0004, wr 0.
  - data_sram_rdata = 0xA1B2C3D4 in HOLD.
  - d_stall high for 3 cycles.
- Store byte, wen 0100, addr 0x2000_0003, wdata 0x5A5A5A5A, addr_ok delayed 4 cycles:
  - addr 0x2000_0002, size 0, wr 1.
  - Request fields stable during all 4 wait cycles.
- Store half, wen 1100, and word store, wen 1111:
  - Size 1 with addr[1:0]=10.
  - Size 2 with aligned addr.
- Read completes while longest_stall=1 for 5 cycles:
  - FSM stays in HOLD with the data held.
  - Exactly one data_req handshake occurs.
- Flush asserted in WAIT:
  - No HOLD; FSM returns to IDLE after data_ok.
  - An en=1 with flush=1 in IDLE produces no data_req.
- With the macro defined, addr_ok and data_ok in the same REQ cycle with longest_stall=0:
  - d_stall low that cycle.
  - rdata equals data_rdata.
  - FSM is in IDLE at the next cycle.

Source files
------------

// File: rtl/d_sram_bridge_pkg.sv
// rtl/d_sram_bridge_pkg.sv - bridge FSM state encodings and bus transfer size constants
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    DSB_IDLE = 2'd0,
    DSB_REQ  = 2'd1,
    DSB_WAIT = 2'd2,
    DSB_HOLD = 2'd3
  } dsb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sram_bridge_if.sv
// rtl/d_sram_bridge_if.sv - handshaked SRAM-like data bus between bridge and arbiter
interface d_sram_bridge_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );

endinterface

// File: rtl/d_sram_bridge_size_dec.sv
// rtl/d_sram_bridge_size_dec.sv - maps byte-lane enables to bus direction, size and address
module d_sram_bridge_size_dec
  import d_sram_bridge_pkg::*;
(
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] bus_addr
);

  // The low address bits are implied by the lane enables, so they are rebuilt rather than passed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Lane pattern selects transfer size and the byte offset; odd patterns fall back to a word write.
  always_comb begin
    wr       = (wen != 4'b0000);
    size     = SIZE_WORD;
    bus_addr = {addr[31:2], 2'b00};
    case (wen)
      4'b0011: size = SIZE_HALF;
      4'b1100: begin
        size     = SIZE_HALF;
        bus_addr = {addr[31:2], 2'b10};
      end
      4'b0001: size = SIZE_BYTE;
      4'b0010: begin
        size     = SIZE_BYTE;
        bus_addr = {addr[31:2], 2'b01};
      end
      4'b0100: begin
        size     = SIZE_BYTE;
        bus_addr = {addr[31:2], 2'b10};
      end
      4'b1000: begin
        size     = SIZE_BYTE;
        bus_addr = {addr[31:2], 2'b11};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/d_sram_bridge.sv
// rtl/d_sram_bridge.sv - M-stage data SRAM port to handshaked bus bridge (option: DSRAM_BRIDGE_RDATA_BYPASS_EN)
module d_sram_bridge
  import d_sram_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  data_sram_en,
  input  logic [3:0]            data_sram_wen,
  input  logic [31:0]           data_sram_addr,
  input  logic [31:0]           data_sram_wdata,
  output logic [31:0]           data_sram_rdata,
  input  logic                  flush,
  input  logic                  longest_stall,
  output logic                  d_stall,
  d_sram_bridge_if.master       bus
);

  dsb_state_t  state_q;
  dsb_state_t  state_d;
  dsb_state_t  done_state;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        flushed_q;

  logic        dec_wr;
  logic [1:0]  dec_size;
  logic [31:0] dec_addr;
  logic        launch;
  logic        done;
  logic        killed;

  d_sram_bridge_size_dec u_size_dec (
    .wen      (data_sram_wen),
    .addr     (data_sram_addr),
    .wr       (dec_wr),
    .size     (dec_size),
    .bus_addr (dec_addr)
  );

  assign launch = (state_q == DSB_IDLE) && data_sram_en && !flush;
  assign done   = ((state_q == DSB_REQ) && bus.data_addr_ok && bus.data_data_ok) ||
                  ((state_q == DSB_WAIT) && bus.data_data_ok);
  // A flush in the completion cycle kills the access just like an earlier, remembered one.
  assign killed = flushed_q || flush;

  assign bus.data_req   = (state_q == DSB_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DSB_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus the pipeline-facing stall and read data.
  always_comb begin
    state_d         = state_q;
    done_state      = DSB_HOLD;
    d_stall         = launch || (state_q == DSB_REQ) || (state_q == DSB_WAIT);
    data_sram_rdata = rdata_q;
    if (killed) done_state = DSB_IDLE;
`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
    else if (!longest_stall) done_state = DSB_IDLE;
    if (done && !killed) begin
      d_stall         = 1'b0;
      data_sram_rdata = bus.data_rdata;
    end
`endif
    case (state_q)
      DSB_IDLE: if (launch) state_d = DSB_REQ;
      DSB_REQ: begin
        if (done)                  state_d = done_state;
        else if (bus.data_addr_ok) state_d = DSB_WAIT;
      end
      DSB_WAIT: if (done) state_d = done_state;
      DSB_HOLD: if (!longest_stall) state_d = DSB_IDLE;
    endcase
  end

  // Request fields captured once at launch, read word on completion, sticky flush tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      flushed_q <= 1'b0;
    end else begin
      if (launch) begin
        wr_q    <= dec_wr;
        size_q  <= dec_size;
        addr_q  <= dec_addr;
        wdata_q <= data_sram_wdata;
      end
      if (done && !wr_q) rdata_q <= bus.data_rdata;
      if (done) flushed_q <= 1'b0;
      else if (((state_q == DSB_REQ) || (state_q == DSB_WAIT)) && flush) flushed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_d_sram_bridge.sv
// tb/tb_d_sram_bridge.sv - directed self-checking bench for d_sram_bridge
module tb_d_sram_bridge;
  import d_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata;
  logic        flush;
  logic        longest_stall;
  logic        d_stall;
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;

  d_sram_bridge_if bus ();

  d_sram_bridge dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (sram_rdata),
    .flush           (flush),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.data_req && bus.data_addr_ok) hs_cnt <= hs_cnt + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         output logic [66:0] obs);
    step; en = 1'b1; wen = w; addr = a; wdata = d; flush = 1'b0; longest_stall = 1'b0;
    step; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    obs = {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata};
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0;
    step; bus.data_data_ok = 1'b0; en = 1'b0;
    step;
  endtask

  task automatic test_reset;
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    flush = 1'b0; longest_stall = 1'b0;
    bus.data_rdata = 32'h0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    step; step;
    @(negedge clk);
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, DSB_IDLE); end
    checks++; if ({bus.data_req, bus.data_wr, bus.data_size} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.data_req, bus.data_wr, bus.data_size}); end
    checks++; if ({bus.data_addr, bus.data_wdata, sram_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bus.data_addr, bus.data_wdata, sram_rdata}); end
    checks++; if ({d_stall, dut.flushed_q} !== 2'b00) begin errors++; $display("FAIL reset_stall_flushed: got %b expected 00", {d_stall, dut.flushed_q}); end
    en = 1'b1; #1;
    checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_eq: got %b expected 1", d_stall); end
    en = 1'b0;
    step; resetn = 1'b1;
  endtask

  task automatic test_read;
    int stalls = 0;
    int exp_stalls;
`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
    exp_stalls = 2;
`else
    exp_stalls = 3;
`endif
    step; en = 1'b1; wen = 4'b0000; addr = 32'h1000_0006; wdata = 32'h0;
    @(negedge clk); if (d_stall) stalls++;
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL read_c0_req: got %b expected 0", bus.data_req); end
    step; bus.data_addr_ok = 1'b1;
    @(negedge clk); if (d_stall) stalls++;
    checks++; if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr} !== {1'b1, 1'b0, 2'd2, 32'h1000_0004}) begin
      errors++; $display("FAIL read_req_fields: got %h expected %h", {bus.data_req, bus.data_wr, bus.data_size, bus.data_addr}, {1'b1, 1'b0, 2'd2, 32'h1000_0004}); end
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA1B2_C3D4;
    @(negedge clk); if (d_stall) stalls++;
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL read_wait_req: got %b expected 0", bus.data_req); end
`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
    checks++; if (sram_rdata !== 32'hA1B2_C3D4) begin errors++; $display("FAIL read_bypass_rdata: got %h expected a1b2c3d4", sram_rdata); end
`endif
    step; bus.data_data_ok = 1'b0; bus.data_rdata = 32'hDEAD_BEEF; en = 1'b0;
    @(negedge clk); if (d_stall) stalls++;
`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL read_bypass_idle: got %0d expected %0d", dut.state_q, DSB_IDLE); end
`else
    checks++; if (dut.state_q !== DSB_HOLD) begin errors++; $display("FAIL read_hold_state: got %0d expected %0d", dut.state_q, DSB_HOLD); end
    checks++; if (sram_rdata !== 32'hA1B2_C3D4) begin errors++; $display("FAIL read_hold_rdata: got %h expected a1b2c3d4", sram_rdata); end
`endif
    checks++; if (stalls !== exp_stalls) begin errors++; $display("FAIL read_stall_cycles: got %0d expected %0d", stalls, exp_stalls); end
    step;
    @(negedge clk);
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL read_end_idle: got %0d expected %0d", dut.state_q, DSB_IDLE); end
  endtask

  task automatic test_store_byte;
    logic [67:0] exp_f;
    exp_f = {1'b1, 1'b1, 2'd0, 32'h2000_0002, 32'h5A5A_5A5A};
    step; en = 1'b1; wen = 4'b0100; addr = 32'h2000_0003; wdata = 32'h5A5A_5A5A;
    for (int i = 0; i < 4; i++) begin
      step; bus.data_addr_ok = 1'b0; wen = 4'b1111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
      @(negedge clk);
      checks++; if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !== exp_f) begin
        errors++; $display("FAIL store_stable_%0d: got %h expected %h", i, {bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata}, exp_f); end
    end
    step; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !== exp_f) begin
      errors++; $display("FAIL store_accept: got %h expected %h", {bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata}, exp_f); end
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    step; bus.data_data_ok = 1'b0; en = 1'b0;
    step;
    @(negedge clk);
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL store_end_idle: got %0d expected %0d", dut.state_q, DSB_IDLE); end
  endtask

  task automatic test_sizes;
    logic [3:0]  w_t [6];
    logic [31:0] a_t [6];
    logic [34:0] e_t [6];
    logic [66:0] obs;
    w_t[0] = 4'b1100; a_t[0] = 32'h3000_0001; e_t[0] = {1'b1, 2'd1, 32'h3000_0002};
    w_t[1] = 4'b1111; a_t[1] = 32'h4000_0007; e_t[1] = {1'b1, 2'd2, 32'h4000_0004};
    w_t[2] = 4'b0011; a_t[2] = 32'h5000_0003; e_t[2] = {1'b1, 2'd1, 32'h5000_0000};
    w_t[3] = 4'b0001; a_t[3] = 32'h5000_000D; e_t[3] = {1'b1, 2'd0, 32'h5000_000C};
    w_t[4] = 4'b1000; a_t[4] = 32'h5000_0010; e_t[4] = {1'b1, 2'd0, 32'h5000_0013};
    w_t[5] = 4'b0110; a_t[5] = 32'h6000_0002; e_t[5] = {1'b1, 2'd2, 32'h6000_0000};
    for (int i = 0; i < 6; i++) begin
      run_txn(w_t[i], a_t[i], 32'hC0DE_0000 + i, obs);
      checks++; if (obs !== {e_t[i], 32'hC0DE_0000 + i}) begin
        errors++; $display("FAIL size_map_%0d: got %h expected %h", i, obs, {e_t[i], 32'hC0DE_0000 + i}); end
    end
  endtask

  task automatic test_long_stall;
    int hs0;
    hs0 = hs_cnt;
    step; en = 1'b1; wen = 4'b0000; addr = 32'h5000_0008; longest_stall = 1'b1;
    step; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1122_3344;
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({dut.state_q, bus.data_req, sram_rdata} !== {DSB_HOLD, 1'b0, 32'h1122_3344}) begin
        errors++; $display("FAIL hold_%0d: got %h expected %h", i, {dut.state_q, bus.data_req, sram_rdata}, {DSB_HOLD, 1'b0, 32'h1122_3344}); end
      if (i < 4) step;
    end
    step; longest_stall = 1'b0; en = 1'b0;
    step;
    @(negedge clk);
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL hold_release: got %0d expected %0d", dut.state_q, DSB_IDLE); end
    checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL hold_handshakes: got %0d expected 1", hs_cnt - hs0); end
  endtask

  task automatic test_flush;
    int hs0;
    step; en = 1'b1; wen = 4'b0000; addr = 32'h6000_0000;
    step; bus.data_addr_ok = 1'b1;
    step; bus.data_addr_ok = 1'b0; flush = 1'b1;
    step; flush = 1'b0;
    @(negedge clk);
    checks++; if ({dut.state_q, dut.flushed_q} !== {DSB_WAIT, 1'b1}) begin
      errors++; $display("FAIL flush_sticky: got %h expected %h", {dut.state_q, dut.flushed_q}, {DSB_WAIT, 1'b1}); end
    step; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL flush_done_stall: got %b expected 1", d_stall); end
    step; bus.data_data_ok = 1'b0; en = 1'b0;
    @(negedge clk);
    checks++; if ({dut.state_q, dut.flushed_q, d_stall} !== {DSB_IDLE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_skip_hold: got %h expected %h", {dut.state_q, dut.flushed_q, d_stall}, {DSB_IDLE, 1'b0, 1'b0}); end
    hs0 = hs_cnt;
    step; en = 1'b1; flush = 1'b1; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if ({d_stall, bus.data_req} !== 2'b00) begin errors++; $display("FAIL flush_idle_stall: got %b expected 00", {d_stall, bus.data_req}); end
    step;
    @(negedge clk);
    checks++; if ({dut.state_q, bus.data_req} !== {DSB_IDLE, 1'b0}) begin
      errors++; $display("FAIL flush_idle_noreq: got %h expected %h", {dut.state_q, bus.data_req}, {DSB_IDLE, 1'b0}); end
    step; en = 1'b0; flush = 1'b0; bus.data_addr_ok = 1'b0;
    checks++; if (hs_cnt !== hs0) begin errors++; $display("FAIL flush_idle_hs: got %0d expected %0d", hs_cnt, hs0); end
  endtask

  task automatic test_reset_mid;
    step; en = 1'b1; wen = 4'b0000; addr = 32'h8000_0000;
    step;
    @(negedge clk);
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %b expected 1", bus.data_req); end
    #1 resetn = 1'b0; en = 1'b0;
    #1;
    checks++; if ({dut.state_q, bus.data_req, bus.data_addr} !== {DSB_IDLE, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rstmid_async: got %h expected %h", {dut.state_q, bus.data_req, bus.data_addr}, {DSB_IDLE, 1'b0, 32'h0}); end
    step; resetn = 1'b1;
  endtask

  task automatic test_back_to_back;
    step; en = 1'b1; wen = 4'b0000; addr = 32'h9000_0000;
    step; bus.data_addr_ok = 1'b1;
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1;
`ifndef DSRAM_BRIDGE_RDATA_BYPASS_EN
    step; bus.data_data_ok = 1'b0;
`endif
    step; bus.data_data_ok = 1'b0; addr = 32'h9000_0104;
    @(negedge clk);
    checks++; if ({dut.state_q, d_stall, bus.data_req} !== {DSB_IDLE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_idle: got %h expected %h", {dut.state_q, d_stall, bus.data_req}, {DSB_IDLE, 1'b1, 1'b0}); end
    step;
    @(negedge clk);
    checks++; if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h9000_0104}) begin
      errors++; $display("FAIL b2b_second_req: got %h expected %h", {bus.data_req, bus.data_addr}, {1'b1, 32'h9000_0104}); end
    bus.data_addr_ok = 1'b1;
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    step; bus.data_data_ok = 1'b0; en = 1'b0;
    step;
  endtask

`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
  task automatic test_bypass;
    step; en = 1'b1; wen = 4'b0000; addr = 32'h7000_000C; longest_stall = 1'b0;
    step; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if ({d_stall, sram_rdata} !== {1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL bypass_cycle: got %h expected %h", {d_stall, sram_rdata}, {1'b0, 32'hCAFE_F00D}); end
    step; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; en = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== DSB_IDLE) begin errors++; $display("FAIL bypass_idle: got %0d expected %0d", dut.state_q, DSB_IDLE); end
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_store_byte;
    test_sizes;
    test_long_stall;
    test_flush;
    test_reset_mid;
    test_back_to_back;
`ifdef DSRAM_BRIDGE_RDATA_BYPASS_EN
    test_bypass;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
